// File: rtl/instr_fetch_unit.sv
// Fetch stage of the single-issue MIPS core.
// Holds the PC, fetches over a req/ack instruction-memory port, latches the
// instruction word and selects the next PC from the decoder's jump/branch bits.
module instr_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          TIMEOUT  = 16,
   parameter int          CNT_W    = 5
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   input  logic        stall,
   input  logic        jump,
   input  logic        branch,
   input  logic        jr,
   input  logic [31:0] jr_target,
   input  logic        alu_zero,
   output logic [31:0] instr,
   output logic [5:0]  opcode,
   output logic [31:0] pc_plus4,
   output logic        instr_valid,
   output logic        fetch_err
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_REQ   = 2'd1,
      S_VALID = 2'd2,
      S_ERR   = 2'd3
   } state_t;

   state_t            state_reg, state_next;
   logic [31:0]       pc_reg, pc_next;
   logic [31:0]       instr_reg, instr_next;
   logic [CNT_W-1:0]  wait_cnt_reg, wait_cnt_next;

   logic [31:0]       seq_pc;
   logic [31:0]       branch_off;
   logic              branch_taken;
   logic [31:0]       target_pc;
   logic              target_bad;

   assign seq_pc     = pc_reg + 32'd4;
   assign branch_off = {{14{instr_reg[15]}}, instr_reg[15:0], 2'b00};
   // bne (opcode 5) inverts the sense of the zero flag relative to beq
   assign branch_taken = branch & (alu_zero ^ (instr_reg[31:26] == 6'd5));

   // Next-PC selection: jr, then jump, then taken branch, else sequential
   always_comb begin
      target_pc  = seq_pc;
      target_bad = 1'b0;
      if (jump && jr) begin
         target_pc  = jr_target;
         target_bad = |jr_target[1:0];
      end else if (jump) begin
         target_pc = {seq_pc[31:28], instr_reg[25:0], 2'b00};
      end else if (branch_taken) begin
         target_pc = seq_pc + branch_off;
      end
   end

   // State and datapath registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg    <= S_IDLE;
         pc_reg       <= RESET_PC;
         instr_reg    <= 32'd0;
         wait_cnt_reg <= '0;
      end else begin
         state_reg    <= state_next;
         pc_reg       <= pc_next;
         instr_reg    <= instr_next;
         wait_cnt_reg <= wait_cnt_next;
      end
   end

   // Next-state logic; ack is only honoured while requesting
   always_comb begin
      state_next    = state_reg;
      pc_next       = pc_reg;
      instr_next    = instr_reg;
      wait_cnt_next = wait_cnt_reg;
      case (state_reg)
         S_IDLE: begin
            state_next    = S_REQ;
            wait_cnt_next = '0;
         end
         S_REQ: begin
            if (imem_ack) begin
               instr_next    = imem_rdata;
               wait_cnt_next = '0;
               state_next    = S_VALID;
            end else begin
               wait_cnt_next = wait_cnt_reg + CNT_W'(1);
               // counter is about to reach TIMEOUT-1 with no ack: give up
               if (wait_cnt_reg == CNT_W'(TIMEOUT - 2)) begin
                  state_next = S_ERR;
               end
            end
         end
         S_VALID: begin
            if (!stall) begin
               if (target_bad) begin
                  state_next = S_ERR;
               end else begin
                  pc_next       = target_pc;
                  wait_cnt_next = '0;
                  state_next    = S_REQ;
               end
            end
         end
         S_ERR: begin
            state_next = S_ERR;
         end
         default: begin
            state_next = S_ERR;
         end
      endcase
   end

   // Moore outputs decoded from the current state
   always_comb begin
      imem_req    = (state_reg == S_REQ);
      instr_valid = (state_reg == S_VALID);
      fetch_err   = (state_reg == S_ERR);
      imem_addr   = pc_reg;
      instr       = instr_reg;
      opcode      = instr_reg[31:26];
      pc_plus4    = seq_pc;
   end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed fetch sequences with a
// cycle-level reference model compared every cycle, plus literal spot checks.
module tb_instr_fetch_unit;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam int          TIMEOUT  = 16;

   logic        clk = 1'b0;
   logic        rst;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        stall, jump, branch, jr, alu_zero;
   logic [31:0] jr_target;
   logic [31:0] instr;
   logic [5:0]  opcode;
   logic [31:0] pc_plus4;
   logic        instr_valid;
   logic        fetch_err;

   int tests = 0;
   int fails = 0;

   instr_fetch_unit #(.RESET_PC(RESET_PC), .TIMEOUT(TIMEOUT), .CNT_W(5)) dut (
      .clk(clk), .rst(rst),
      .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .stall(stall), .jump(jump), .branch(branch), .jr(jr),
      .jr_target(jr_target), .alu_zero(alu_zero),
      .instr(instr), .opcode(opcode), .pc_plus4(pc_plus4),
      .instr_valid(instr_valid), .fetch_err(fetch_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      tests++;
      if (got !== want) begin
         fails++;
         $display("FAIL %s: got %h, want %h at %0t", name, got, want, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // mode: 0 idle, 1 requesting, 2 holding a valid instruction, 3 error
   int          m_mode;
   int          m_wait;
   logic [31:0] m_pc, m_instr;
   logic        m_started = 1'b0;
   logic [32:0] m_nx;

   // returns {misaligned, next pc}
   function automatic logic [32:0] model_next(input logic [31:0] pc, input logic [31:0] ins,
                                              input logic j, input logic b, input logic r,
                                              input logic z, input logic [31:0] jt);
      logic [31:0] seq;
      int          off;
      seq = pc + 32'd4;
      if (j && r) return {(jt % 4) != 0, jt};
      if (j) return {1'b0, (seq & 32'hF000_0000) | ((ins & 32'h03FF_FFFF) << 2)};
      off = int'($signed(ins[15:0])) * 4;
      if (b && (z != ((ins >> 26) == 32'd5))) return {1'b0, seq + 32'(off)};
      return {1'b0, seq};
   endfunction

   assign m_nx = model_next(m_pc, m_instr, jump, branch, jr, alu_zero, jr_target);

   always @(posedge clk) begin
      if (rst) begin
         m_started <= 1'b1;
         m_mode    <= 0;
         m_pc      <= RESET_PC;
         m_instr   <= 32'd0;
         m_wait    <= 0;
      end else begin
         case (m_mode)
            0: m_mode <= 1;
            1: begin
               if (imem_ack) begin
                  m_instr <= imem_rdata;
                  m_wait  <= 0;
                  m_mode  <= 2;
               end else begin
                  m_wait <= m_wait + 1;
                  if (m_wait + 1 >= TIMEOUT - 1) m_mode <= 3;
               end
            end
            2: begin
               if (!stall) begin
                  if (m_nx[32]) m_mode <= 3;
                  else begin
                     m_pc   <= m_nx[31:0];
                     m_mode <= 1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   // Per-cycle comparison against the model, away from the active edge
   always @(negedge clk) begin
      if (m_started) begin
         check("cyc_req", imem_req, m_mode == 1);
         check("cyc_valid", instr_valid, m_mode == 2);
         check("cyc_err", fetch_err, m_mode == 3);
         if (m_mode == 1) check("cyc_addr", imem_addr, m_pc);
         if (m_mode == 2) begin
            check("cyc_instr", instr, m_instr);
            check("cyc_opcode", opcode, m_instr >> 26);
            check("cyc_pc_plus4", pc_plus4, m_pc + 32'd4);
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_ctrl();
      stall = 1'b0; jump = 1'b0; branch = 1'b0; jr = 1'b0;
      alu_zero = 1'b0; jr_target = 32'd0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      imem_ack = 1'b0;
      clear_ctrl();
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic wait_req();
      int n = 0;
      while (!imem_req && n < 40) begin
         tick();
         n++;
      end
      if (!imem_req) check("wait_req_bound", 32'd0, 32'd1);
   endtask

   // zero-wait fetch: acks in the first request cycle, returns in the valid cycle
   task automatic req_ack(input logic [31:0] exp_addr, input logic [31:0] data);
      wait_req();
      $display("[TB] fetch addr=%h (expect %h) data=%h", imem_addr, exp_addr, data);
      check("fetch_addr", imem_addr, exp_addr);
      imem_ack   = 1'b1;
      imem_rdata = data;
      tick();
      imem_ack   = 1'b0;
      imem_rdata = $urandom;
   endtask

   task automatic decode(input logic j, input logic b, input logic r, input logic z,
                         input logic [31:0] jt);
      jump = j; branch = b; jr = r; alu_zero = z; jr_target = jt;
      tick();
      clear_ctrl();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      imem_rdata = 32'd0;
      do_reset();

      // reset state and start-up latency
      check("rst_req", imem_req, 1'b0);
      check("rst_valid", instr_valid, 1'b0);
      check("rst_err", fetch_err, 1'b0);
      check("rst_instr", instr, 32'd0);
      check("rst_addr", imem_addr, RESET_PC);
      tick();
      check("first_req", imem_req, 1'b1);

      // 1: sequential addi stream
      req_ack(32'h0, 32'h2008_0005);
      check("t1_opcode", opcode, 6'd8);
      check("t1_valid", instr_valid, 1'b1);
      decode(0, 0, 0, 0, 0);
      check("t1_valid_drop", instr_valid, 1'b0);
      req_ack(32'h4, 32'h2008_0005);
      decode(0, 0, 0, 0, 0);
      req_ack(32'h8, 32'h2008_0005);
      decode(0, 0, 0, 0, 0);
      // j to 0x40
      req_ack(32'hC, 32'h0800_0010);
      decode(1, 0, 0, 0, 0);

      // 2: beq -1 taken then not taken, bne taken, jump beats branch
      req_ack(32'h40, 32'h1000_FFFF);
      decode(0, 1, 0, 1, 0);
      req_ack(32'h40, 32'h1000_FFFF);
      decode(0, 1, 0, 0, 0);
      req_ack(32'h44, 32'h1400_0002);
      decode(0, 1, 0, 0, 0);
      req_ack(32'h50, 32'h0800_0020);
      decode(1, 1, 0, 1, 0);
      req_ack(32'h80, 32'h0000_0008);
      decode(1, 0, 1, 0, 32'h1000_0000);

      // 3: j within region, wrap at top of memory, misaligned jr
      req_ack(32'h1000_0000, 32'h0800_0010);
      decode(1, 0, 0, 0, 0);
      req_ack(32'h1000_0040, 32'h0000_0008);
      decode(1, 0, 1, 0, 32'hFFFF_FFFC);
      req_ack(32'hFFFF_FFFC, 32'h2008_0005);
      check("wrap_pc_plus4", pc_plus4, 32'h0);
      decode(0, 0, 0, 0, 0);
      req_ack(32'h0, 32'h0000_0008);
      decode(1, 0, 1, 0, 32'h0000_0102);
      check("jr_misalign_err", fetch_err, 1'b1);
      check("jr_misalign_req", imem_req, 1'b0);
      tick(); tick(); tick();
      check("err_sticky", fetch_err, 1'b1);
      check("err_no_req", imem_req, 1'b0);

      // 5: stall holds the instruction and pc
      do_reset();
      req_ack(32'h0, 32'h2008_0005);
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("stall_instr", instr, 32'h2008_0005);
         check("stall_opcode", opcode, 6'd8);
         check("stall_addr", imem_addr, 32'h0);
         check("stall_valid", instr_valid, 1'b1);
      end
      stall = 1'b0;
      tick();
      check("stall_release_req", imem_req, 1'b1);
      check("stall_release_addr", imem_addr, 32'h4);

      // 4: fetch timeout
      do_reset();
      wait_req();
      for (int i = 0; i < 14; i++) tick();
      check("to_cycle15_req", imem_req, 1'b1);
      check("to_cycle15_err", fetch_err, 1'b0);
      tick();
      check("to_cycle16_err", fetch_err, 1'b1);
      check("to_cycle16_req", imem_req, 1'b0);
      tick();
      imem_ack   = 1'b1;
      imem_rdata = 32'h2008_0005;
      tick();
      imem_ack   = 1'b0;
      check("to_late_ack_err", fetch_err, 1'b1);
      check("to_late_ack_valid", instr_valid, 1'b0);
      check("to_late_ack_instr", instr, 32'd0);

      // 6: reset while waiting for ack
      do_reset();
      wait_req();
      tick(); tick(); tick();
      rst = 1'b1;
      tick();
      check("midrst_req", imem_req, 1'b0);
      check("midrst_valid", instr_valid, 1'b0);
      rst        = 1'b0;
      imem_ack   = 1'b1;
      imem_rdata = 32'hDEAD_BEEF;
      tick();
      imem_ack   = 1'b0;
      check("midrst_restart_req", imem_req, 1'b1);
      check("midrst_restart_valid", instr_valid, 1'b0);
      req_ack(RESET_PC, 32'h2008_0005);
      check("midrst_instr", instr, 32'h2008_0005);
      decode(0, 0, 0, 0, 0);
      tick();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
